// File: rtl/tc_buffer_reader.sv
// tc_buffer_reader: read-side sequencer for the tensor-core operand buffer.
// Waits for the buffer to report ready, then sweeps addresses 0..N-1 for
// (repeat_cnt+1) passes and presents each word through a registered
// valid/ready output stage.
// Optional feature macro: TC_RD_STALL_CNT_EN adds a saturating 16-bit
// stall_cycles counter output.
`timescale 1ns/1ps

module tc_buffer_reader #(
  parameter int DATA_WIDTH   = 128,
  parameter int BUFFER_DEPTH = 2,
  parameter int ADDR_WIDTH   = 1,
  parameter int REPEAT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     num_entries,
  input  logic [REPEAT_WIDTH-1:0] repeat_cnt,
  input  logic                    buf_ready,
  output logic                    buf_rd_en,
  output logic [ADDR_WIDTH-1:0]   buf_rd_addr,
  input  logic [DATA_WIDTH-1:0]   buf_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done
`ifdef TC_RD_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    STREAM,
    DRAIN
  } state_t;

  localparam logic [ADDR_WIDTH:0]     DepthW  = (ADDR_WIDTH+1)'(BUFFER_DEPTH);
  localparam logic [ADDR_WIDTH:0]     EntOne  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0]   AddrOne = ADDR_WIDTH'(1);
  localparam logic [REPEAT_WIDTH-1:0] PassOne = REPEAT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     nEnt_q, nEnt_d;
  logic [REPEAT_WIDTH-1:0] passMax_q, passMax_d;
  logic [REPEAT_WIDTH-1:0] pass_q, pass_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    mValid_q, mValid_d;
  logic                    mLast_q, mLast_d;
  logic [DATA_WIDTH-1:0]   mData_q, mData_d;
  logic                    busy_q, busy_d;

  logic                    load;
  logic                    lastAddr;
  logic                    finalBeat;
  logic                    doneNow;
  logic [ADDR_WIDTH:0]     clampEnt;

  // A request for more words than the buffer holds is clamped to its depth.
  assign clampEnt  = (num_entries > DepthW) ? DepthW : num_entries;

  // A new word is fetched whenever the output register is empty or being drained.
  assign load      = (state_q == STREAM) && (!mValid_q || m_ready);
  assign lastAddr  = ({1'b0, addr_q} == (nEnt_q - EntOne));
  assign finalBeat = lastAddr && (pass_q == passMax_q);

  // Next-state and datapath decisions; every signal defaults to holding its value.
  always_comb begin
    state_d   = state_q;
    nEnt_d    = nEnt_q;
    passMax_d = passMax_q;
    pass_d    = pass_q;
    addr_d    = addr_q;
    mValid_d  = mValid_q;
    mLast_d   = mLast_q;
    mData_d   = mData_q;
    busy_d    = busy_q;
    doneNow   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          nEnt_d    = clampEnt;
          passMax_d = repeat_cnt;
          addr_d    = '0;
          pass_d    = '0;
          busy_d    = 1'b1;
          mValid_d  = 1'b0;
          mLast_d   = 1'b0;
          state_d   = (clampEnt == '0) ? DRAIN : WAIT_RDY;
        end
      end

      WAIT_RDY: begin
        if (buf_ready) begin
          state_d = STREAM;
        end
      end

      STREAM: begin
        if (load) begin
          mData_d  = buf_data;
          mValid_d = 1'b1;
          mLast_d  = finalBeat;
          if (lastAddr) begin
            addr_d = '0;
            pass_d = pass_q + PassOne;
          end else begin
            addr_d = addr_q + AddrOne;
          end
          if (finalBeat) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (mValid_q && m_ready) begin
          mValid_d = 1'b0;
          mLast_d  = 1'b0;
        end
        if (!mValid_q) begin
          doneNow = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and the output register; reset discards any in-flight beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      nEnt_q    <= '0;
      passMax_q <= '0;
      pass_q    <= '0;
      addr_q    <= '0;
      mValid_q  <= 1'b0;
      mLast_q   <= 1'b0;
      mData_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nEnt_q    <= nEnt_d;
      passMax_q <= passMax_d;
      pass_q    <= pass_d;
      addr_q    <= addr_d;
      mValid_q  <= mValid_d;
      mLast_q   <= mLast_d;
      mData_q   <= mData_d;
      busy_q    <= busy_d;
    end
  end

`ifdef TC_RD_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count cycles where a beat is waiting on the consumer, saturating at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if (busy_q && mValid_q && !m_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

  assign buf_rd_en   = load;
  assign buf_rd_addr = addr_q;
  assign m_valid     = mValid_q;
  assign m_data      = mData_q;
  assign m_last      = mLast_q;
  assign busy        = busy_q;
  assign done        = doneNow;

endmodule

// File: tb/tb_tc_buffer_reader.sv
// tb_tc_buffer_reader: directed self-checking bench for tc_buffer_reader.
`timescale 1ns/1ps

module tb_tc_buffer_reader;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [1:0]   num_entries;
  logic [3:0]   repeat_cnt;
  logic         buf_ready;
  logic         buf_rd_en;
  logic [0:0]   buf_rd_addr;
  logic [127:0] buf_data;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         m_last;
  logic         busy;
  logic         done;
`ifdef TC_RD_STALL_CNT_EN
  logic [15:0]  stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  logic [127:0] wordA;
  logic [127:0] wordB;
  logic [127:0] mem [2];

  tc_buffer_reader dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .num_entries (num_entries),
    .repeat_cnt  (repeat_cnt),
    .buf_ready   (buf_ready),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_addr (buf_rd_addr),
    .buf_data    (buf_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
`ifdef TC_RD_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  // Buffer model: combinational read when enabled.
  assign buf_data = buf_rd_en ? mem[buf_rd_addr] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] n, input logic [3:0] r);
    start       = 1'b1;
    num_entries = n;
    repeat_cnt  = r;
    cyc();
    start       = 1'b0;
    #1;
  endtask

  initial begin : main
    int beats;
    logic sawDone;

    wordA  = {32{4'hA}};
    wordB  = {32{4'hB}};
    mem[0] = wordA;
    mem[1] = wordB;

    rstn        = 1'b0;
    start       = 1'b0;
    num_entries = 2'd0;
    repeat_cnt  = 4'd0;
    buf_ready   = 1'b1;
    m_ready     = 1'b1;

    // Reset state
    cyc();
    cyc();
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rd_en", buf_rd_en, 0);
    checkOutput("rst_rd_addr", buf_rd_addr, 0);
    rstn = 1'b1;
    cyc();

    // Single pass of two words, start ignored while busy
    $display("[TB] single pass");
    applyStimulus(2'd2, 4'd0);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_wait_rd_en", buf_rd_en, 0);
    start = 1'b1;
    num_entries = 2'd0;
    cyc();
    start = 1'b0;
    #1;
    checkOutput("t1_ignore_start_rd_en", buf_rd_en, 1);
    checkOutput("t1_rd_addr0", buf_rd_addr, 0);
    checkOutput("t1_valid_before", m_valid, 0);
    cyc();
    checkOutput("t1_beatA_valid", m_valid, 1);
    checkOutput("t1_beatA_data", m_data, wordA);
    checkOutput("t1_beatA_last", m_last, 0);
    checkOutput("t1_rd_addr1", buf_rd_addr, 1);
    cyc();
    checkOutput("t1_beatB_data", m_data, wordB);
    checkOutput("t1_beatB_last", m_last, 1);
    checkOutput("t1_drain_rd_en", buf_rd_en, 0);
    checkOutput("t1_done_early", done, 0);
    cyc();
    checkOutput("t1_valid_clear", m_valid, 0);
    checkOutput("t1_done", done, 1);
    cyc();
    checkOutput("t1_done_pulse", done, 0);
    checkOutput("t1_busy_low", busy, 0);

    // Three passes of two words
    $display("[TB] three passes");
    applyStimulus(2'd2, 4'd2);
    cyc();
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput($sformatf("t2_rd_en_%0d", i), buf_rd_en, 1);
      checkOutput($sformatf("t2_rd_addr_%0d", i), buf_rd_addr, 128'(i % 2));
      cyc();
      checkOutput($sformatf("t2_data_%0d", i), m_data, (i % 2 == 1) ? wordB : wordA);
      checkOutput($sformatf("t2_last_%0d", i), m_last, (i == 5) ? 128'd1 : 128'd0);
    end
    checkOutput("t2_drain_rd_en", buf_rd_en, 0);
    cyc();
    checkOutput("t2_done", done, 1);
    cyc();
    checkOutput("t2_busy_low", busy, 0);

    // Downstream stall on the first beat
    $display("[TB] stall");
    applyStimulus(2'd2, 4'd0);
    cyc();
    cyc();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("t3_hold_valid_%0d", i), m_valid, 1);
      checkOutput($sformatf("t3_hold_data_%0d", i), m_data, wordA);
      checkOutput($sformatf("t3_hold_rd_en_%0d", i), buf_rd_en, 0);
      cyc();
    end
    m_ready = 1'b1;
    #1;
    checkOutput("t3_hold_data_last", m_data, wordA);
    checkOutput("t3_resume_rd_en", buf_rd_en, 1);
    checkOutput("t3_resume_addr", buf_rd_addr, 1);
    cyc();
    checkOutput("t3_beatB_data", m_data, wordB);
    checkOutput("t3_beatB_last", m_last, 1);
`ifdef TC_RD_STALL_CNT_EN
    checkOutput("t3_stall_cycles", stall_cycles, 3);
`endif
    cyc();
    checkOutput("t3_done", done, 1);
    cyc();
    checkOutput("t3_busy_low", busy, 0);
`ifdef TC_RD_STALL_CNT_EN
    checkOutput("t3_stall_hold", stall_cycles, 3);
`endif

    // Buffer not ready for five cycles
    $display("[TB] wait for ready");
    buf_ready = 1'b0;
    applyStimulus(2'd2, 4'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("t4_wait_rd_en_%0d", i), buf_rd_en, 0);
      checkOutput($sformatf("t4_wait_valid_%0d", i), m_valid, 0);
      cyc();
    end
    buf_ready = 1'b1;
    #1;
    checkOutput("t4_rise_rd_en", buf_rd_en, 0);
    cyc();
    checkOutput("t4_stream_rd_en", buf_rd_en, 1);
    cyc();
    checkOutput("t4_beatA_data", m_data, wordA);
    cyc();
    checkOutput("t4_beatB_data", m_data, wordB);
    cyc();
    checkOutput("t4_done", done, 1);
    cyc();

    // Zero entries: immediate completion
    $display("[TB] zero entries");
    applyStimulus(2'd0, 4'd3);
    checkOutput("t5_zero_done", done, 1);
    checkOutput("t5_zero_busy", busy, 1);
    checkOutput("t5_zero_valid", m_valid, 0);
    checkOutput("t5_zero_rd_en", buf_rd_en, 0);
    cyc();
    checkOutput("t5_zero_done_pulse", done, 0);
    checkOutput("t5_zero_busy_low", busy, 0);

    // Three entries clamped to buffer depth
    $display("[TB] clamp");
    applyStimulus(2'd3, 4'd0);
    beats = 0;
    sawDone = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (done) begin
        sawDone = 1'b1;
        break;
      end
      if (m_valid && m_ready) beats++;
    end
    checkOutput("t5_clamp_done_seen", sawDone, 1);
    checkOutput("t5_clamp_beats", 128'(beats), 2);
    cyc();

    // Reset after the first beat of a six-beat job, then a clean rerun
    $display("[TB] reset mid-job");
    applyStimulus(2'd2, 4'd2);
    cyc();
    cyc();
    checkOutput("t6_first_beat", m_data, wordA);
    rstn = 1'b0;
    #1;
    checkOutput("t6_rst_valid", m_valid, 0);
    checkOutput("t6_rst_data", m_data, 0);
    checkOutput("t6_rst_last", m_last, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_rd_en", buf_rd_en, 0);
    checkOutput("t6_rst_rd_addr", buf_rd_addr, 0);
    checkOutput("t6_rst_done", done, 0);
    rstn = 1'b1;
    cyc();
    applyStimulus(2'd2, 4'd2);
    beats = 0;
    sawDone = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (done) begin
        sawDone = 1'b1;
        break;
      end
      if (m_valid && m_ready) begin
        checkOutput($sformatf("t6_rerun_data_%0d", beats), m_data, (beats % 2 == 1) ? wordB : wordA);
        checkOutput($sformatf("t6_rerun_last_%0d", beats), m_last, (beats == 5) ? 128'd1 : 128'd0);
        beats++;
      end
    end
    checkOutput("t6_rerun_done_seen", sawDone, 1);
    checkOutput("t6_rerun_beats", 128'(beats), 6);
    cyc();
    checkOutput("t6_rerun_busy_low", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
